bomb_slot: RTL and testbench

- One bomb instance; it is the responder end of the bomb-system drop/blast handshake.
- It accepts a single-cycle drop pulse, latches a grid-snapped position, and counts down a fuse in seconds.
- It then shows a cross-shaped explosion for a fixed number of frames, and returns a single-cycle blast pulse when the slot is free again.
- It drives bomb and blast draw-request/RGB for the video mux; the bomb system instantiates one per bomb slot.

---
 rtl/bomb_pkg.sv | 31 +++
 rtl/bomb_cross_render.sv | 37 +++
 rtl/bomb_slot.sv | 168 ++++++++++++++++
 tb/tb_bomb_slot.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared types, geometry and colour constants for the bomb slot and its renderer.
package bomb_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, EXPLODING} slot_state_t;

    localparam int TILE_LOG2  = 5;
    localparam int TILE_SIZE  = 1 << TILE_LOG2;
    localparam int MAX_RADIUS = 4;

    localparam logic [7:0] BOMB_COLOR = 8'h49;
    localparam logic [7:0] BOMB_FLASH = 8'hE0;
    localparam logic [7:0] BLAST_CORE = 8'hFF;
    localparam logic [7:0] BLAST_ARM  = 8'hF4;

    // Round to the nearest tile origin; the 12-bit sum keeps the carry before the shift.
    function automatic logic [10:0] snap_to_tile(input logic [10:0] pos);
        logic [11:0] rounded;
        rounded = {1'b0, pos} + 12'(TILE_SIZE / 2);
        return 11'((rounded >> TILE_LOG2) << TILE_LOG2);
    endfunction

    function automatic logic [2:0] clamp_radius(input logic [2:0] req);
        if (req == 3'd0)
            return 3'd1;
        else if (req > 3'(MAX_RADIUS))
            return 3'(MAX_RADIUS);
        else
            return req;
    endfunction

endpackage

// File: rtl/bomb_cross_render.sv
// Combinational hit test for the bomb square and the cross-shaped blast around it.
module bomb_cross_render
    import bomb_pkg::*;
(
    input  logic [10:0] bomb_x,
    input  logic [10:0] bomb_y,
    input  logic [2:0]  radius,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        in_square,
    output logic        in_cross
);

    localparam logic signed [11:0] TILE_LAST = 12'(TILE_SIZE - 1);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] reach;
    logic               in_col;
    logic               in_row;
    logic               h_span;
    logic               v_span;

    // Offsets from the bomb origin never overflow 12 bits, so arms past the edge simply clip.
    assign dx    = $signed({1'b0, pixel_x}) - $signed({1'b0, bomb_x});
    assign dy    = $signed({1'b0, pixel_y}) - $signed({1'b0, bomb_y});
    assign reach = 12'(radius) << TILE_LOG2;

    assign in_col = (dx >= 12'sd0) && (dx <= TILE_LAST);
    assign in_row = (dy >= 12'sd0) && (dy <= TILE_LAST);
    assign h_span = (dx >= -reach) && (dx <= reach + TILE_LAST);
    assign v_span = (dy >= -reach) && (dy <= reach + TILE_LAST);

    assign in_square = in_col && in_row;
    assign in_cross  = (in_row && h_span) || (in_col && v_span);

endmodule

// File: rtl/bomb_slot.sv
// One bomb slot: arm on drop, count the fuse, show the explosion, then pulse blast when free.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_SECONDS   = 3,
    parameter int EXPLODE_FRAMES = 30,
    parameter int FLASH_FRAMES   = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        drop_bomb_key,
    input  logic        OneSecPulse,
    input  logic        startOfFrame,
    input  logic        abort,
    input  logic [10:0] player_topLeftX,
    input  logic [10:0] player_topLeftY,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [2:0]  blast_num,
    output logic        bombDR,
    output logic [7:0]  bombRGB,
    output logic        blastDR,
    output logic [7:0]  blastRGB,
    output logic        blast,
    output logic        explode
);

    localparam int FUSE_W  = $clog2(FUSE_SECONDS + 1);
    localparam int FRAME_W = $clog2(EXPLODE_FRAMES + 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

    slot_state_t        state, next_state;
    logic [FUSE_W-1:0]  fuse_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [FLASH_W-1:0] flash_cnt;
    logic               flash_phase;
    logic [10:0]        bomb_x, bomb_y;
    logic [2:0]         radius;

    logic               load_pos, enter_blast, final_sec, fuse_done, frames_done;
    logic [10:0]        bomb_x_d, bomb_y_d;
    logic [2:0]         radius_d;
    logic               hit_square, hit_cross;
    logic               bomb_dr_d, blast_dr_d, blast_d, explode_d;
    logic [7:0]         bomb_rgb_d, blast_rgb_d;

    assign fuse_done   = (fuse_cnt == FUSE_W'(FUSE_SECONDS));
    assign frames_done = (frame_cnt == FRAME_W'(EXPLODE_FRAMES));
    assign final_sec   = (state == ARMED) && (fuse_cnt == FUSE_W'(FUSE_SECONDS - 1));
    assign load_pos    = (state == IDLE) && drop_bomb_key && !abort;
    assign enter_blast = (state == ARMED) && (next_state == EXPLODING);

    // The renderer sees the values that will be live after this edge, so output
    // registers line up with the state that the same edge enters.
    assign bomb_x_d = load_pos    ? snap_to_tile(player_topLeftX) : bomb_x;
    assign bomb_y_d = load_pos    ? snap_to_tile(player_topLeftY) : bomb_y;
    assign radius_d = enter_blast ? clamp_radius(blast_num)       : radius;

    bomb_cross_render u_render (
        .bomb_x    (bomb_x_d),
        .bomb_y    (bomb_y_d),
        .radius    (radius_d),
        .pixel_x   (pixelX),
        .pixel_y   (pixelY),
        .in_square (hit_square),
        .in_cross  (hit_cross)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        next_state = state;
        if (abort)
            next_state = IDLE;
        else begin
            case (state)
                IDLE:      if (drop_bomb_key) next_state = ARMED;
                ARMED:     if (fuse_done)     next_state = EXPLODING;
                EXPLODING: if (frames_done)   next_state = IDLE;
                default:                      next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fuse_cnt    <= '0;
            frame_cnt   <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
            bomb_x      <= '0;
            bomb_y      <= '0;
            radius      <= '0;
        end else if (abort) begin
            fuse_cnt    <= '0;
            frame_cnt   <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else begin
            if (load_pos) begin
                bomb_x   <= bomb_x_d;
                bomb_y   <= bomb_y_d;
                fuse_cnt <= '0;
            end else if (state == ARMED && OneSecPulse) begin
                fuse_cnt <= fuse_cnt + 1'b1;
            end

            if (enter_blast) begin
                frame_cnt <= '0;
                radius    <= radius_d;
            end else if (state == EXPLODING && startOfFrame) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            // Flash phase 0 shows BOMB_FLASH, so the final second starts on the alternate colour.
            if (!final_sec) begin
                flash_cnt   <= '0;
                flash_phase <= 1'b0;
            end else if (startOfFrame) begin
                if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
                    flash_cnt   <= '0;
                    flash_phase <= ~flash_phase;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bomb_dr_d   = (next_state == ARMED) && hit_square;
        blast_dr_d  = (next_state == EXPLODING) && hit_cross;
        bomb_rgb_d  = 8'h00;
        blast_rgb_d = 8'h00;
        if (bomb_dr_d)
            bomb_rgb_d = (final_sec && !flash_phase) ? BOMB_FLASH : BOMB_COLOR;
        if (blast_dr_d)
            blast_rgb_d = hit_square ? BLAST_CORE : BLAST_ARM;
        blast_d   = (state == EXPLODING) && frames_done && !abort;
        explode_d = (next_state == EXPLODING);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bombDR   <= 1'b0;
            bombRGB  <= 8'h00;
            blastDR  <= 1'b0;
            blastRGB <= 8'h00;
            blast    <= 1'b0;
            explode  <= 1'b0;
        end else begin
            bombDR   <= bomb_dr_d;
            bombRGB  <= bomb_rgb_d;
            blastDR  <= blast_dr_d;
            blastRGB <= blast_rgb_d;
            blast    <= blast_d;
            explode  <= explode_d;
        end
    end

endmodule

// File: tb/tb_bomb_slot.sv
// Directed self-checking bench for bomb_slot: drop, fuse, flash, blast shape, clamp, clip, abort.
module tb_bomb_slot;

    logic        clk;
    logic        resetN;
    logic        drop_bomb_key;
    logic        OneSecPulse;
    logic        startOfFrame;
    logic        abort;
    logic [10:0] player_topLeftX;
    logic [10:0] player_topLeftY;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [2:0]  blast_num;
    logic        bombDR;
    logic [7:0]  bombRGB;
    logic        blastDR;
    logic [7:0]  blastRGB;
    logic        blast;
    logic        explode;

    int n_checks = 0;
    int n_fail   = 0;

    bomb_slot dut (
        .clk             (clk),
        .resetN          (resetN),
        .drop_bomb_key   (drop_bomb_key),
        .OneSecPulse     (OneSecPulse),
        .startOfFrame    (startOfFrame),
        .abort           (abort),
        .player_topLeftX (player_topLeftX),
        .player_topLeftY (player_topLeftY),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .blast_num       (blast_num),
        .bombDR          (bombDR),
        .bombRGB         (bombRGB),
        .blastDR         (blastDR),
        .blastRGB        (blastRGB),
        .blast           (blast),
        .explode         (explode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sec();
        OneSecPulse = 1'b1;
        tick();
        OneSecPulse = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
    endtask

    task automatic drop_at(input logic [10:0] x, input logic [10:0] y);
        player_topLeftX = x;
        player_topLeftY = y;
        drop_bomb_key   = 1'b1;
        tick();
        drop_bomb_key   = 1'b0;
    endtask

    task automatic probe(input logic [10:0] x, input logic [10:0] y);
        pixelX = x;
        pixelY = y;
        tick();
    endtask

    task automatic arm_and_fire(input logic [10:0] x, input logic [10:0] y, input logic [2:0] bn);
        blast_num = bn;
        drop_at(x, y);
        sec();
        sec();
        sec();
        tick();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    int blast_seen;

    initial begin
        resetN = 1'b0;
        drop_bomb_key = 1'b0;
        OneSecPulse = 1'b0;
        startOfFrame = 1'b0;
        abort = 1'b0;
        player_topLeftX = '0;
        player_topLeftY = '0;
        pixelX = '0;
        pixelY = '0;
        blast_num = 3'd2;

        #12;
        check("rst_bombDR",   bombDR,   0);
        check("rst_bombRGB",  bombRGB,  0);
        check("rst_blastDR",  blastDR,  0);
        check("rst_blastRGB", blastRGB, 0);
        check("rst_blast",    blast,    0);
        check("rst_explode",  explode,  0);
        resetN = 1'b1;

        // Idle: pulses do nothing, pixel on the reset bomb position stays dark
        tick();
        sec();
        sec();
        sec();
        frames(3);
        probe(0, 0);
        check("idle_bombDR",  bombDR,  0);
        check("idle_blastDR", blastDR, 0);
        check("idle_explode", explode, 0);
        check("idle_blast",   blast,   0);

        // Drop at (100,70) snaps to (96,64)
        blast_num = 3'd2;
        drop_at(100, 70);
        probe(96, 64);
        check("snap_tl_dr",  bombDR,  1);
        check("snap_tl_rgb", bombRGB, 8'h49);
        check("snap_tl_blastDR", blastDR, 0);
        probe(127, 95);
        check("snap_br_dr", bombDR, 1);
        probe(128, 64);
        check("snap_right_dr",  bombDR,  0);
        check("snap_right_rgb", bombRGB, 8'h00);
        probe(96, 63);
        check("snap_above_dr", bombDR, 0);

        // Second drop while armed is ignored
        drop_at(500, 500);
        probe(96, 64);
        check("redrop_old_dr", bombDR, 1);
        probe(512, 512);
        check("redrop_new_dr", bombDR, 0);

        // Fuse and flash
        sec();
        probe(100, 70);
        check("fuse1_rgb", bombRGB, 8'h49);
        sec();
        probe(100, 70);
        check("flash_start_rgb", bombRGB, 8'hE0);
        frames(7);
        check("flash_7_rgb", bombRGB, 8'hE0);
        frames(1);
        tick();
        check("flash_8_rgb", bombRGB, 8'h49);
        frames(7);
        check("flash_15_rgb", bombRGB, 8'h49);
        frames(1);
        tick();
        check("flash_16_rgb", bombRGB, 8'hE0);

        // Third pulse: explode one cycle later
        sec();
        check("pulse3_explode", explode, 0);
        check("pulse3_bombDR",  bombDR,  1);
        tick();
        check("boom_explode",  explode,  1);
        check("boom_bombDR",   bombDR,   0);
        check("boom_core_dr",  blastDR,  1);
        check("boom_core_rgb", blastRGB, 8'hFF);

        // Blast shape, radius 2 around tile (3,2)
        probe(32, 80);
        check("arm_left_dr",  blastDR,  1);
        check("arm_left_rgb", blastRGB, 8'hF4);
        probe(110, 0);
        check("arm_up_dr", blastDR, 1);
        probe(32, 0);
        check("diag_dr",  blastDR,  0);
        check("diag_rgb", blastRGB, 8'h00);
        probe(191, 70);
        check("arm_right_edge_dr", blastDR, 1);
        probe(192, 70);
        check("arm_right_out_dr", blastDR, 0);

        // End of explosion after 30 frames
        frames(29);
        check("f29_explode", explode, 1);
        frames(1);
        check("f30_blast",   blast,   0);
        check("f30_explode", explode, 1);
        tick();
        check("end_blast",   blast,   1);
        check("end_explode", explode, 0);
        tick();
        check("end_blast_off", blast, 0);

        // blast_num 0 clamps to 1, then abort mid-explosion
        arm_and_fire(100, 70, 3'd0);
        check("r1_explode", explode, 1);
        probe(64, 70);
        check("r1_edge_dr", blastDR, 1);
        probe(63, 70);
        check("r1_out_dr", blastDR, 0);
        do_abort();
        check("abort_explode", explode, 0);
        check("abort_blastDR", blastDR, 0);
        blast_seen = 0;
        for (int i = 0; i < 40; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            if (blast) blast_seen++;
        end
        check("abort_no_blast", blast_seen, 0);

        // blast_num 7 clamps to 4
        arm_and_fire(100, 70, 3'd7);
        probe(255, 70);
        check("r4_right_dr", blastDR, 1);
        probe(256, 70);
        check("r4_right_out", blastDR, 0);
        probe(100, 223);
        check("r4_down_dr", blastDR, 1);
        probe(100, 224);
        check("r4_down_out", blastDR, 0);
        do_abort();

        // Corner bomb at (0,0), radius 4: clipped arms, no wrap
        arm_and_fire(10, 12, 3'd4);
        probe(0, 0);
        check("corner_core_rgb", blastRGB, 8'hFF);
        probe(159, 10);
        check("corner_x159", blastDR, 1);
        probe(160, 10);
        check("corner_x160", blastDR, 0);
        probe(2047, 10);
        check("corner_wrap_x", blastDR, 0);
        probe(2020, 0);
        check("corner_wrap_x2", blastDR, 0);
        probe(10, 2047);
        check("corner_wrap_y", blastDR, 0);
        probe(10, 159);
        check("corner_y159", blastDR, 1);
        do_abort();

        // abort wins over a simultaneous drop
        player_topLeftX = 300;
        player_topLeftY = 300;
        drop_bomb_key = 1'b1;
        abort = 1'b1;
        tick();
        drop_bomb_key = 1'b0;
        abort = 1'b0;
        probe(288, 288);
        check("abort_drop_bombDR", bombDR, 0);
        sec();
        sec();
        sec();
        tick();
        check("abort_drop_explode", explode, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
